// File: rtl/operand_stack.sv
// -----------------------------------------------------------------------------
// operand_stack
//
// Hardware operand stack that feeds an external combinational ALU. PUSH, DROP,
// CLEAR and NOP finish in the cycle they are accepted. UNARY, BINARY and SELECT
// take one extra cycle (OPER). During that cycle the ALU sees the top three
// entries, and its result is written back into the new top slot.
//
// Build option:
//   OPSTACK_ERR_TRAP_EN  undefined : err is a one-cycle pulse after a faulting
//                                    accept.
//                        defined   : err is sticky. Every command except CLEAR
//                                    is accepted and ignored while err is high.
//                                    CLEAR clears err and count together.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                000 NOP, 001 PUSH, 010 DROP, 011 UNARY,
//                         100 BINARY, 101 SELECT, 110 CLEAR, 111 NOP
//   cmd_alu               ALU control code for UNARY/BINARY/SELECT
//   cmd_data              value written by PUSH
//   alu_a/alu_b/alu_c     top, second and third entry (0 below the bottom)
//   alu_ctrl              registered ALU control code
//   alu_result            combinational result from the ALU
//   top                   current top entry (0 when empty)
//   count                 number of valid entries
//   busy                  high while an ALU operation is in flight
//   err                   underflow/overflow indication
// -----------------------------------------------------------------------------
module operand_stack #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [3:0]                   cmd_alu,
  input  logic [DW-1:0]                cmd_data,
  output logic [DW-1:0]                alu_a,
  output logic [DW-1:0]                alu_b,
  output logic [DW-1:0]                alu_c,
  output logic [3:0]                   alu_ctrl,
  input  logic [31:0]                  alu_result,
  output logic [DW-1:0]                top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, OPER} state_t;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_PUSH   = 3'b001,
    OP_DROP   = 3'b010,
    OP_UNARY  = 3'b011,
    OP_BINARY = 3'b100,
    OP_SELECT = 3'b101,
    OP_CLEAR  = 3'b110,
    OP_NOP7   = 3'b111
  } op_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [1:0]      pops_q;     // entries consumed by the in-flight ALU op
  logic            live_q;     // low until the first edge after reset release
  logic            err_q;
  logic [3:0]      alu_ctrl_q;

  logic [DW-1:0]   mem [DEPTH];

  op_t             op;
  logic            accept;
  logic            blocked;
  logic [1:0]      need;
  logic            full;
  logic            empty;
  logic            underflow;
  logic [CW-1:0]   need_ext;
  logic [CW-1:0]   pops_ext;
  logic [CW-1:0]   cnt_m1;
  logic [CW-1:0]   cnt_m2;
  logic [CW-1:0]   cnt_m3;
  logic [CW-1:0]   wb_idx;
  logic [DW-1:0]   res_dw;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;

  assign op       = op_t'(cmd_op);
  assign cmd_ready = live_q && (state_q == IDLE);
  assign accept   = cmd_valid && cmd_ready;
  assign busy     = (state_q == OPER);
  assign err      = err_q;
  assign alu_ctrl = alu_ctrl_q;
  assign count    = count_q;

`ifdef OPSTACK_ERR_TRAP_EN
  assign blocked = err_q;
`else
  assign blocked = 1'b0;
`endif

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign need_ext = {{(CW-2){1'b0}}, need};
  assign pops_ext = {{(CW-2){1'b0}}, pops_q};
  assign cnt_m1   = count_q - CW'(1);
  assign cnt_m2   = count_q - CW'(2);
  assign cnt_m3   = count_q - CW'(3);
  assign wb_idx   = count_q - pops_ext;
  assign underflow = (need != 2'd0) && (count_q < need_ext);

  // ALU result is 32 bits wide; fit it to the entry width.
  generate
    if (DW == 32) begin : g_res_eq
      assign res_dw = alu_result;
    end else if (DW > 32) begin : g_res_ext
      assign res_dw = {{(DW-32){1'b0}}, alu_result};
    end else begin : g_res_trunc
      assign res_dw = alu_result[DW-1:0];
    end
  endgenerate

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    need = 2'd0;
    case (op)
      OP_UNARY:  need = 2'd1;
      OP_BINARY: need = 2'd2;
      OP_SELECT: need = 2'd3;
      default:   need = 2'd0;
    endcase
  end

  // Operand taps: anything below the bottom of the stack reads as zero, so
  // stale storage is never visible.
  assign alu_a = (count_q >= CW'(1)) ? mem[cnt_m1[AW-1:0]] : '0;
  assign alu_b = (count_q >= CW'(2)) ? mem[cnt_m2[AW-1:0]] : '0;
  assign alu_c = (count_q >= CW'(3)) ? mem[cnt_m3[AW-1:0]] : '0;
  assign top   = alu_a;

  // Single write port, shared by PUSH and ALU writeback. These never collide
  // because commands are not accepted in OPER.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = count_q[AW-1:0];
    mem_wdata = cmd_data;
    if (state_q == OPER) begin
      mem_we    = 1'b1;
      mem_waddr = wb_idx[AW-1:0];
      mem_wdata = res_dw;
    end else if (accept && !blocked && (op == OP_PUSH) && !full) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the storage array has no reset. count gates every read, so stale
  // entries are never observable, and leaving them unreset lets the array map
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      pops_q     <= 2'd0;
      live_q     <= 1'b0;
      err_q      <= 1'b0;
      alu_ctrl_q <= 4'd0;
    end else begin
      live_q <= 1'b1;
`ifndef OPSTACK_ERR_TRAP_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (op == OP_CLEAR) begin
              count_q <= '0;
              err_q   <= 1'b0;
            end else if (!blocked) begin
              case (op)
                OP_PUSH: begin
                  if (full) err_q   <= 1'b1;
                  else      count_q <= count_q + CW'(1);
                end
                OP_DROP: begin
                  if (empty) err_q   <= 1'b1;
                  else       count_q <= cnt_m1;
                end
                OP_UNARY, OP_BINARY, OP_SELECT: begin
                  if (underflow) begin
                    err_q <= 1'b1;
                  end else begin
                    alu_ctrl_q <= cmd_alu;
                    pops_q     <= need;
                    state_q    <= OPER;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        OPER: begin
          // Pop the operands, push the single result.
          count_q <= wb_idx + CW'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_stack.sv
// -----------------------------------------------------------------------------
// tb_operand_stack
//
// Directed bench for operand_stack at the default configuration (DEPTH=16,
// DW=32). A small ALU model closes the loop:
//   0000 a+b, 0001 b-a, 0010 ~a, 0011 a+1, 0100 (a==0 ? b : c)
// A table of single-command vectors covers the main function. Hand-written
// sequences cover reset, the ALU timing, overflow, error behaviour and reset
// during OPER.
// -----------------------------------------------------------------------------
module tb_operand_stack;

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, DROP = 3'b010,
                         UNARY = 3'b011, BINARY = 3'b100, SELECT = 3'b101,
                         CLEAR = 3'b110, NOP7 = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_alu;
  logic [31:0] cmd_data;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [31:0] top;
  logic [4:0]  count;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  operand_stack #(.DEPTH(16), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_alu   (cmd_alu),
    .cmd_data  (cmd_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .alu_ctrl  (alu_ctrl),
    .alu_result(alu_result),
    .top       (top),
    .count     (count),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_b - alu_a;
      4'b0010: alu_result = ~alu_a;
      4'b0011: alu_result = alu_a + 32'd1;
      4'b0100: alu_result = (alu_a == 32'd0) ? alu_b : alu_c;
      default: alu_result = 32'd0;
    endcase
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [3:0]  alu;
    logic [31:0] data;
    logic [31:0] exp_top;
    logic [4:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one command at the falling edge. The bench returns 1 ns after the
  // accepting rising edge, with cmd_valid already dropped.
  task automatic issue(input logic [2:0] op, input logic [3:0] alu, input logic [31:0] data);
    int n;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_alu   = alu;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) check("busy_timeout", {63'd0, busy}, 64'd0);
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] op, input logic [3:0] alu,
                              input logic [31:0] data, input logic [31:0] t,
                              input logic [4:0] c, input logic e);
    vec_t v;
    v.name = name; v.op = op; v.alu = alu; v.data = data;
    v.exp_top = t; v.exp_cnt = c; v.exp_err = e;
    return v;
  endfunction

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    cmd_alu   = 4'd0;
    cmd_data  = 32'd0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_top", 64'(top), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 64'(cmd_ready), 64'd1);

    // ---------------- PUSH 5, PUSH 3, BINARY sub ----------------
    issue(PUSH, 4'd0, 32'd5);
    issue(PUSH, 4'd0, 32'd3);
    issue(BINARY, 4'b0001, 32'd0);
    check("oper_ready", 64'(cmd_ready), 64'd0);
    check("oper_busy", 64'(busy), 64'd1);
    check("oper_alu_a", 64'(alu_a), 64'd3);
    check("oper_alu_b", 64'(alu_b), 64'd5);
    check("oper_alu_c", 64'(alu_c), 64'd0);
    check("oper_alu_ctrl", 64'(alu_ctrl), 64'b0001);
    @(posedge clk);
    #1;
    check("wb_ready", 64'(cmd_ready), 64'd1);
    check("wb_busy", 64'(busy), 64'd0);
    check("wb_top", 64'(top), 64'd2);
    check("wb_count", 64'(count), 64'd1);
    check("wb_alu_ctrl_hold", 64'(alu_ctrl), 64'b0001);

    // ---------------- table-driven vectors ----------------
    vecs.push_back(mk("drop_last",    DROP,   4'd0,    32'd0,          32'd0,          5'd0, 1'b0));
`ifndef OPSTACK_ERR_TRAP_EN
    vecs.push_back(mk("drop_empty",   DROP,   4'd0,    32'd0,          32'd0,          5'd0, 1'b1));
    vecs.push_back(mk("unary_empty",  UNARY,  4'b0010, 32'd0,          32'd0,          5'd0, 1'b1));
`endif
    vecs.push_back(mk("push7",        PUSH,   4'd0,    32'd7,          32'd7,          5'd1, 1'b0));
    vecs.push_back(mk("push9",        PUSH,   4'd0,    32'd9,          32'd9,          5'd2, 1'b0));
    vecs.push_back(mk("push0",        PUSH,   4'd0,    32'd0,          32'd0,          5'd3, 1'b0));
    vecs.push_back(mk("select_b",     SELECT, 4'b0100, 32'd0,          32'd9,          5'd1, 1'b0));
    vecs.push_back(mk("unary_inc",    UNARY,  4'b0011, 32'd0,          32'd10,         5'd1, 1'b0));
`ifndef OPSTACK_ERR_TRAP_EN
    vecs.push_back(mk("binary_under", BINARY, 4'b0000, 32'd0,          32'd10,         5'd1, 1'b1));
`endif
    vecs.push_back(mk("push_max",     PUSH,   4'd0,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2, 1'b0));
    vecs.push_back(mk("binary_wrap",  BINARY, 4'b0000, 32'd0,          32'd9,          5'd1, 1'b0));
    vecs.push_back(mk("push4",        PUSH,   4'd0,    32'd4,          32'd4,          5'd2, 1'b0));
    vecs.push_back(mk("push6",        PUSH,   4'd0,    32'd6,          32'd6,          5'd3, 1'b0));
    vecs.push_back(mk("select_c",     SELECT, 4'b0100, 32'd0,          32'd9,          5'd1, 1'b0));
`ifndef OPSTACK_ERR_TRAP_EN
    vecs.push_back(mk("select_under", SELECT, 4'b0100, 32'd0,          32'd9,          5'd1, 1'b1));
`endif
    vecs.push_back(mk("nop0",         NOP,    4'd0,    32'd0,          32'd9,          5'd1, 1'b0));
    vecs.push_back(mk("nop7",         NOP7,   4'd0,    32'd0,          32'd9,          5'd1, 1'b0));
    vecs.push_back(mk("unary_not",    UNARY,  4'b0010, 32'd0,          32'hFFFF_FFF6,  5'd1, 1'b0));
    vecs.push_back(mk("clear",        CLEAR,  4'd0,    32'd0,          32'd0,          5'd0, 1'b0));

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].alu, vecs[i].data);
      wait_idle();
      check({vecs[i].name, "_top"}, 64'(top), 64'(vecs[i].exp_top));
      check({vecs[i].name, "_count"}, 64'(count), 64'(vecs[i].exp_cnt));
      check({vecs[i].name, "_err"}, 64'(err), 64'(vecs[i].exp_err));
    end
    check("clear_alu_b", 64'(alu_b), 64'd0);
    check("clear_alu_c", 64'(alu_c), 64'd0);

    // ---------------- overflow ----------------
    for (int i = 0; i < 16; i++) issue(PUSH, 4'd0, 32'd100 + 32'(i));
    check("full_count", 64'(count), 64'd16);
    check("full_top", 64'(top), 64'd115);
    issue(PUSH, 4'd0, 32'hDEAD);
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_count", 64'(count), 64'd16);
    check("ovf_top", 64'(top), 64'd115);
    issue(DROP, 4'd0, 32'd0);
`ifndef OPSTACK_ERR_TRAP_EN
    check("drop_after_ovf_count", 64'(count), 64'd15);
    check("drop_after_ovf_top", 64'(top), 64'd114);
    check("drop_after_ovf_err", 64'(err), 64'd0);
`else
    check("trap_drop_ignored", 64'(count), 64'd16);
    check("trap_err_sticky", 64'(err), 64'd1);
`endif
    issue(CLEAR, 4'd0, 32'd0);
    check("ovf_clear_count", 64'(count), 64'd0);
    check("ovf_clear_err", 64'(err), 64'd0);

    // ---------------- underflow on empty stack ----------------
    issue(BINARY, 4'b0000, 32'd0);
    check("uf_err", 64'(err), 64'd1);
    check("uf_busy", 64'(busy), 64'd0);
    check("uf_ready", 64'(cmd_ready), 64'd1);
    check("uf_count", 64'(count), 64'd0);
`ifndef OPSTACK_ERR_TRAP_EN
    @(posedge clk);
    #1;
    check("uf_err_pulse_end", 64'(err), 64'd0);
`else
    repeat (3) @(posedge clk);
    #1;
    check("uf_err_held", 64'(err), 64'd1);
    issue(PUSH, 4'd0, 32'd42);
    check("uf_push_ignored", 64'(count), 64'd0);
    check("uf_err_still", 64'(err), 64'd1);
    issue(CLEAR, 4'd0, 32'd0);
    check("uf_clear_err", 64'(err), 64'd0);
    check("uf_clear_count", 64'(count), 64'd0);
`endif

    // ---------------- reset during OPER ----------------
    issue(PUSH, 4'd0, 32'd1);
    issue(PUSH, 4'd0, 32'd2);
    issue(BINARY, 4'b0000, 32'd0);
    check("mid_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_top", 64'(top), 64'd0);
    check("mid_rst_ready", 64'(cmd_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready_low", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rel_ready", 64'(cmd_ready), 64'd1);
    check("rel_top", 64'(top), 64'd0);
    check("rel_count", 64'(count), 64'd0);
    @(posedge clk);
    #1;
    check("rel_no_writeback", 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
